// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Definitions shared by the multiply/divide unit and its bench: the RV32M
// funct3 operation encoding, the controller state encoding, and the default
// operand width.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // RV32M funct3 values; bit 2 separates multiply (0) from divide (1).
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes. The
// quotient register doubles as the dividend shift register: its MSB is shifted
// into the partial remainder and the new quotient bit enters at its LSB.
//
// Ports
//   i_rem     [XLEN-1:0]  partial remainder before the step
//   i_quo     [XLEN-1:0]  remaining dividend bits / quotient bits so far
//   i_divisor [XLEN-1:0]  divisor magnitude
//   o_rem     [XLEN-1:0]  partial remainder after the step
//   o_quo     [XLEN-1:0]  quotient register after the step
// -----------------------------------------------------------------------------
module div_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // Partial remainder is always below the divisor, so a borrow shows up
    // as the extra MSB of the difference.
    assign w_fits  = ~w_diff[XLEN];

    assign o_rem = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit with a valid/ready request side and a
// valid/ready result side. Operands are converted to unsigned magnitudes on
// accept, processed one bit per cycle, and sign-corrected when the result is
// registered. Divide-by-zero and signed overflow finish one cycle after accept.
//
// Configuration macro
//   MULDIV_FAST_MUL_EN  when defined, multiplies use a single-cycle full
//                       multiplier and finish one cycle after accept.
//
// Ports
//   clk        clock, all state changes on rising edge
//   reset      synchronous active-high reset
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   op   [2:0] funct3 operation code
//   A    [XLEN-1:0] rs1 operand
//   B    [XLEN-1:0] rs2 operand
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     registered result
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            r_state, w_state_next;
    op_e               r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_mcand;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]   r_hi;        // product high half or partial remainder
    logic [XLEN-1:0]   r_lo;        // multiplier/product low half or quotient
    logic              r_neg;       // final result must be negated
    logic              r_div_zero;
    logic              r_div_ovf;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    // ---------------- request decode (used only on accept) ----------------
    op_e               w_op;
    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_res_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;

    assign w_op       = op_e'(op);
    assign w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV)  || (w_op == OP_REM);
    assign w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_a_neg    = w_a_signed & A[XLEN-1];
    assign w_b_neg    = w_b_signed & B[XLEN-1];
    assign w_a_mag    = w_a_neg ? -A : A;
    assign w_b_mag    = w_b_neg ? -B : B;
    // Remainder follows the dividend; quotient and products follow both signs.
    assign w_res_neg  = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // ---------------- multiply datapath ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;

`ifdef MULDIV_FAST_MUL_EN
    assign w_prod = {{XLEN{1'b0}}, r_mcand} * {{XLEN{1'b0}}, r_lo};
`else
    logic [XLEN:0]     w_mul_sum;

    // Shift-add: conditionally add the multiplicand to the high half, then
    // shift {carry, high, low} right; the multiplier drains out of r_lo.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_prod    = {r_hi, r_lo};
`endif

    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_mul_res  = (r_op == OP_MUL) ? w_prod_fix[XLEN-1:0]
                                         : w_prod_fix[2*XLEN-1:XLEN];

    // ---------------- divide datapath ----------------
    logic [XLEN-1:0]   w_step_rem, w_step_quo;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_div_res;
    logic              w_is_rem, w_div_special;

    div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem     (r_hi),
        .i_quo     (r_lo),
        .i_divisor (r_mcand),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign w_is_rem      = (r_op == OP_REM) || (r_op == OP_REMU);
    assign w_div_special = r_div_zero | r_div_ovf;
    assign w_quo_fix     = r_neg ? -r_lo : r_lo;
    assign w_rem_fix     = r_neg ? -r_hi : r_hi;

    always_comb begin
        if (r_div_zero)
            w_div_res = w_is_rem ? r_a : '1;
        else if (r_div_ovf)
            w_div_res = w_is_rem ? '0 : r_a;
        else
            w_div_res = w_is_rem ? w_rem_fix : w_quo_fix;
    end

    // ---------------- controller ----------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_next = op[2] ? DIV : MUL;
            end
            MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                w_state_next = DONE;
`else
                if (r_cnt == '0)
                    w_state_next = DONE;
`endif
            end
            DIV: begin
                if (w_div_special || (r_cnt == '0))
                    w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: only the counter and the visible result are reset; the operand
    // and working registers are always reloaded on accept before being used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= w_op;
                        r_a        <= A;
                        r_mcand    <= op[2] ? w_b_mag : w_a_mag;
                        r_lo       <= op[2] ? w_a_mag : w_b_mag;
                        r_hi       <= '0;
                        r_neg      <= w_res_neg;
                        r_div_zero <= (B == '0);
                        r_div_ovf  <= ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                                      (A == MOST_NEG) && (B == '1);
                        r_cnt      <= CNT_W'(XLEN);
                    end
                end
                MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    r_result <= w_mul_res;
                    r_cnt    <= '0;
`else
                    if (r_cnt != '0) begin
                        r_hi  <= w_mul_sum[XLEN:1];
                        r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_result <= w_mul_res;
                    end
`endif
                end
                DIV: begin
                    if (w_div_special || (r_cnt == '0)) begin
                        r_result <= w_div_res;
                        r_cnt    <= '0;
                    end else begin
                        r_hi  <= w_step_rem;
                        r_lo  <= w_step_quo;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit (XLEN=32). A driver issues requests and pushes
// the expected result and latency into a scoreboard queue; a monitor pops and
// compares each time the unit presents a new result. Honours
// MULDIV_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif
    localparam int LAT_DIV = 33;
    localparam int LAT_SPC = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              acc;
        string           name;
    } exp_t;

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        int              lat;
        string           name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request, wait for acceptance, then scramble the inputs so a
    // unit that fails to latch its operands produces a wrong answer.
    task automatic issue(input vec_t v);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({v.name, " ready to accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = v.op;
        A        = v.a;
        B        = v.b;
        sb.push_back('{v.res, v.lat, cyc + 1, v.name});
        @(negedge clk);
        in_valid = 1'b0;
        op       = 3'($urandom);
        A        = $urandom;
        B        = $urandom;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, " result delivered"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare on the first cycle of every out_valid episode.
    logic seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected result: got 0x%08h expected none", result);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, result, e.res);
                check({e.name, " latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   guard;

        vecs.push_back('{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL, "MUL 7*-3"});
        vecs.push_back('{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL, "MULHU max*max"});
        vecs.push_back('{OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, LAT_MUL, "MULH min*min"});
        vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL, "MULHSU -1*max"});
        vecs.push_back('{OP_MULH,   32'hFFFFFFFD,   32'd5,        32'hFFFFFFFF, LAT_MUL, "MULH -3*5"});
        vecs.push_back('{OP_MULHU,  32'h12345678,   32'h10,       32'h00000001, LAT_MUL, "MULHU x*16"});
        vecs.push_back('{OP_MUL,    32'h12345678,   32'h10,       32'h23456780, LAT_MUL, "MUL x*16"});
        vecs.push_back('{OP_DIV,    32'hFFFFFFEC,   32'd3,        32'hFFFFFFFA, LAT_DIV, "DIV -20/3"});
        vecs.push_back('{OP_REM,    32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, LAT_DIV, "REM -20/3"});
        vecs.push_back('{OP_DIVU,   32'hFFFFFFEC,   32'd3,        32'h5555554E, LAT_DIV, "DIVU big/3"});
        vecs.push_back('{OP_REMU,   32'hFFFFFFEC,   32'd3,        32'h00000002, LAT_DIV, "REMU big/3"});
        vecs.push_back('{OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, LAT_DIV, "DIV 7/-2"});
        vecs.push_back('{OP_REM,    32'd7,          32'hFFFFFFFE, 32'h00000001, LAT_DIV, "REM 7/-2"});
        vecs.push_back('{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, LAT_SPC, "DIVU 5/0"});
        vecs.push_back('{OP_REM,    32'd5,          32'd0,        32'h00000005, LAT_SPC, "REM 5/0"});
        vecs.push_back('{OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, LAT_SPC, "DIV 5/0"});
        vecs.push_back('{OP_REMU,   32'd5,          32'd0,        32'h00000005, LAT_SPC, "REMU 5/0"});
        vecs.push_back('{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, LAT_SPC, "DIV min/-1"});
        vecs.push_back('{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, LAT_SPC, "REM min/-1"});
        vecs.push_back('{OP_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, LAT_DIV, "DIVU 2^31/max"});
        vecs.push_back('{OP_REMU,   32'h80000000,   32'hFFFFFFFF, 32'h80000000, LAT_DIV, "REMU 2^31/max"});

        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = 3'd0;
        A         = 32'd1;
        B         = 32'd1;
        repeat (3) @(negedge clk);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result",    result,         32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i]);
            drain(vecs[i].name);
        end

        // Backpressure: hold the result for 5 cycles, then release.
        out_ready = 1'b0;
        v = '{OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_DIV, "DIVU 100/7 held"};
        issue(v);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("hold out_valid rises", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold result",    result,          32'd14);
            check("hold out_valid", 32'(out_valid),  32'd1);
            check("hold in_ready",  32'(in_ready),   32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release in_ready",  32'(in_ready),  32'd1);
        drain("DIVU 100/7 held");

        // Reset during iteration 10 of a divide, with inputs active.
        v = '{OP_DIV, 32'd1000, 32'd7, 32'd142, LAT_DIV, "DIV aborted"};
        issue(v);
        repeat (9) @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready",  32'(in_ready),  32'd1);
        check("abort result",    result,         32'd0);

        v = '{OP_MUL, 32'd3, 32'd4, 32'd12, LAT_MUL, "MUL 3*4 after reset"};
        issue(v);
        drain(v.name);

        repeat (3) @(negedge clk);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (>=8, even).
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: op  input  3  operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port: A  input  XLEN  operand rs1.
REQ-008 SHALL have port: B  input  XLEN  operand rs2.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  XLEN  registered result.

Function
REQ-012 SHALL use states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-013 SHALL accept a request on edge E0 where in_valid && in_ready, capturing op, A and B; later changes to A, B and op SHALL be ignored.
REQ-014 SHALL, on accept, go to MUL for op 0-3 and to DIV for op 4-7, with the iteration counter loaded to XLEN.
REQ-015 SHALL perform one shift-add (MUL) or restoring-subtract (DIV) step per cycle on unsigned magnitudes, on edges E1..E(XLEN).
REQ-016 SHALL apply sign fix-up, register result and enter DONE on edge E(XLEN+1), so out_valid is high from E(XLEN+1).
REQ-017 SHALL form a 2*XLEN product: MUL returns the low half; MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands.
REQ-018 SHALL round signed quotients toward zero, and the remainder SHALL take the sign of the dividend.
REQ-019 SHALL handle divide-by-zero by going directly from the accept to DONE on E1: DIV/DIVU return all-ones, REM/REMU return A.
REQ-020 SHALL handle signed overflow (A = most negative, B = -1) by going directly to DONE on E1: DIV returns A, REM returns 0.
REQ-021 SHALL hold result and out_valid stable in DONE while out_ready=0.
REQ-022 SHALL return to IDLE on an edge where out_valid && out_ready, with in_ready=1 on the following cycle; no new request is accepted in that same cycle.
REQ-023 SHALL have an iteration counter of width $clog2(XLEN+1) that never wraps; the exit condition is counter==0.

Reset
REQ-024 SHALL, on reset, force state IDLE, in_ready=1, out_valid=0, result=0 and counter=0, including mid-operation; any in-flight operation is discarded.
REQ-025 SHALL give reset priority over a simultaneous in_valid or out_ready.

Configuration
REQ-026 SHALL, with MULDIV_FAST_MUL_EN defined, compute op 0-3 with a single-cycle full multiplier, registering the result into DONE on E1 so out_valid is high from E1.
REQ-027 SHALL, with MULDIV_FAST_MUL_EN undefined, use the iterative multiplier per REQ-015/016; divide timing is identical in both builds.

Structure
REQ-028 SHALL take from shared package muldiv_pkg: the op enum (funct3 values), the state enum and the XLEN default constant.
REQ-029 SHALL place one combinational divide step (shift, trial subtract, quotient bit) in sub-module div_step, instantiated once.

Verification (XLEN=32)
REQ-030 SHALL cover MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid at E33 (E1 with MULDIV_FAST_MUL_EN).
REQ-031 SHALL cover the high-half products:
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 SHALL cover DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA and REM -> 0xFFFFFFFE, out_valid at E33.
REQ-033 SHALL cover the special cases, each with out_valid at E1:
- DIVU 5/0 -> 0xFFFFFFFF.
- REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM 0x80000000/0xFFFFFFFF -> 0.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset asserted at iteration 10 of a DIV -> next cycle out_valid=0, in_ready=1; a following MUL 3×4 -> 12.
